// File: rtl/u_p.sv
// 8-bit accumulator microprocessor with a 32x8 unified RAM and a fetch/decode/execute FSM.
// Init loads a built-in "read two operands, output their sum, halt" program.
module u_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int SUM_ADDR = 30
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              Enter,
  input  logic              Init,
  input  logic [DATA_W-1:0] Input,
  output logic              Halt,
  output logic [DATA_W-1:0] Output,
  output logic [10:0]       CtrlSignals,
  output logic [2:0]        Ins,
  // Debug/back-door access: RAM preload/readback and visible PC and FSM state
  input  logic              dbg_wr_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        state_o
);

  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SUM_A = ADDR_W'(SUM_ADDR);
  localparam logic [ADDR_W-1:0] ZERO_A = '0;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_INWAIT  = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] mem_d [MEM_WORDS];

  logic              ir_load, jmp_mux, pc_load, meminst, mem_wr;
  logic [1:0]        asel;
  logic              a_load, sub, outen, halt;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              a_zero;

  assign opcode    = ir_q[DATA_W-1 -: 3];
  assign operand   = ir_q[ADDR_W-1:0];
  assign a_zero    = (a_q == '0);
  assign mem_addr  = meminst ? operand : pc_q;
  assign mem_rdata = mem_q[mem_addr];

  // Control decode; everything is forced idle while RESET or Init is active,
  // which also suppresses any RAM write of an instruction being aborted.
  always_comb begin
    state_d = state_q;
    ir_load = 1'b0;
    jmp_mux = 1'b0;
    pc_load = 1'b0;
    meminst = 1'b0;
    mem_wr  = 1'b0;
    asel    = 2'b00;
    a_load  = 1'b0;
    sub     = 1'b0;
    outen   = 1'b0;
    halt    = 1'b0;
    if (!RESET && !Init) begin
      case (state_q)
        ST_FETCH: begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          state_d = ST_DECODE;
        end
        ST_DECODE: begin
          meminst = 1'b1;
          state_d = ST_EXECUTE;
        end
        ST_EXECUTE: begin
          state_d = ST_FETCH;
          case (opcode)
            OP_LOAD: begin
              meminst = 1'b1;
              asel    = 2'b10;
              a_load  = 1'b1;
            end
            OP_STORE: begin
              meminst = 1'b1;
              mem_wr  = 1'b1;
            end
            OP_ADD: begin
              meminst = 1'b1;
              a_load  = 1'b1;
            end
            OP_SUB: begin
              meminst = 1'b1;
              a_load  = 1'b1;
              sub     = 1'b1;
            end
            OP_IN: begin
              if (Enter) begin
                asel    = 2'b01;
                a_load  = 1'b1;
                state_d = ST_INWAIT;
              end else begin
                state_d = ST_EXECUTE;
              end
            end
            OP_JZ: begin
              if (a_zero) begin
                jmp_mux = 1'b1;
                pc_load = 1'b1;
              end
            end
            OP_JPOS: begin
              if (!a_q[DATA_W-1] && !a_zero) begin
                jmp_mux = 1'b1;
                pc_load = 1'b1;
              end
            end
            OP_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
          endcase
        end
        // Holding here until Enter drops makes one Enter pulse feed exactly one IN.
        ST_INWAIT: begin
          if (!Enter) state_d = ST_FETCH;
        end
        ST_HALT: begin
          halt    = 1'b1;
          outen   = 1'b1;
          state_d = ST_HALT;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pc_load) pc_d = jmp_mux ? operand : pc_q + 1'b1;
    ir_d = ir_load ? mem_rdata : ir_q;
    a_d  = a_q;
    if (a_load) begin
      case (asel)
        2'b00:   a_d = sub ? a_q - mem_rdata : a_q + mem_rdata;
        2'b01:   a_d = Input;
        2'b10:   a_d = mem_rdata;
        default: a_d = a_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
    end else if (Init) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
    end
  end

  // RAM has no reset: its contents survive RESET and change only via Init or writes.
  always_comb begin
    mem_d = mem_q;
    if (Init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem_d[i] = '0;
      mem_d[0] = {OP_IN,    ZERO_A};
      mem_d[1] = {OP_STORE, SUM_A};
      mem_d[2] = {OP_IN,    ZERO_A};
      mem_d[3] = {OP_ADD,   SUM_A};
      mem_d[4] = {OP_HALT,  ZERO_A};
    end else begin
      if (mem_wr)   mem_d[mem_addr]   = a_q;
      if (dbg_wr_i) mem_d[dbg_addr_i] = dbg_wdata_i;
    end
  end

  always_ff @(posedge CLOCK) begin
    mem_q <= mem_d;
  end

  assign CtrlSignals = {ir_load, jmp_mux, pc_load, meminst, mem_wr, asel, a_load, sub, outen, halt};
  assign Halt        = halt;
  assign Output      = a_q;
  assign Ins         = opcode;
  assign dbg_rdata_o = mem_q[dbg_addr_i];
  assign pc_o        = pc_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_u_p.sv
// Directed bench for u_p: operand entry via Enter handshake, sum output, halt,
// reset while halted, and a preloaded LOAD/SUB/JZ/JPOS branch program.
module tb_u_p;

  logic       clk = 1'b0;
  logic       RESET, Enter, Init;
  logic [7:0] Input;
  logic       Halt;
  logic [7:0] Output;
  logic [10:0] CtrlSignals;
  logic [2:0] Ins;
  logic       dbg_wr;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic [4:0] pc;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_INWAIT = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;
  localparam logic [2:0] OP_IN     = 3'b100;

  always #5 clk = ~clk;

  u_p dut (
    .CLOCK(clk), .RESET(RESET), .Enter(Enter), .Init(Init), .Input(Input),
    .Halt(Halt), .Output(Output), .CtrlSignals(CtrlSignals), .Ins(Ins),
    .dbg_wr_i(dbg_wr), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata), .pc_o(pc), .state_o(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_in(input string tag);
    int n = 0;
    while (!(state == ST_EXEC && Ins == OP_IN) && n < 60) begin
      tick();
      n++;
    end
    check(tag, (state == ST_EXEC && Ins == OP_IN), 1);
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!Halt && n < 80) begin
      tick();
      n++;
    end
    check(tag, Halt, 1);
  endtask

  task automatic feed(input logic [7:0] d, input int hold, input string tag);
    wait_in({tag, "_reach_in"});
    Input = d;
    Enter = 1'b1;
    tick();
    check({tag, "_a_after_in"}, Output, exp_q.pop_front());
    repeat (hold - 1) tick();
    Enter = 1'b0;
    tick();
  endtask

  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input string tag);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(a + b);
    feed(a, 2, {tag, "_op1"});
    feed(b, 1, {tag, "_op2"});
    wait_halt({tag, "_halt"});
    check({tag, "_sum"}, Output, exp_q.pop_front());
  endtask

  task automatic reset_init();
    RESET = 1'b1;
    Init  = 1'b1;
    Enter = 1'b0;
    #1;
    check("rst_halt", Halt, 0);
    check("rst_out", Output, 0);
    check("rst_ctrl", CtrlSignals, 0);
    tick();
    check("rst_pc", pc, 0);
    RESET = 1'b0;
    Init  = 1'b0;
  endtask

  logic [7:0] boot_prog [5];
  logic [7:0] br_prog [9];

  initial begin
    boot_prog = '{8'h80, 8'h3E, 8'h80, 8'h5E, 8'hE0};
    br_prog   = '{8'h0A, 8'h6A, 8'hA5, 8'hE0, 8'hE0, 8'h0B, 8'hC3, 8'h2C, 8'hE0};
    RESET = 1'b0; Enter = 1'b0; Init = 1'b0; Input = 8'h00;
    dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick();

    // No Enter: core parks in the first IN
    reset_init();
    repeat (8) tick();
    check("stall_pc", pc, 1);
    check("stall_ins", Ins, OP_IN);
    check("stall_halt", Halt, 0);
    check("stall_out", Output, 0);

    // Basic sum, then Output must hold while halted
    run_add(8'h25, 8'h13, "sum1");
    repeat (5) tick();
    check("halt_hold_out", Output, 8'h38);
    check("halt_hold_halt", Halt, 1);
    check("halt_pc", pc, 5);

    // Wrapping add
    reset_init();
    run_add(8'hF0, 8'h20, "wrap");

    // Long Enter: only one operand consumed, second IN waits for a new pulse
    reset_init();
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h55);
    wait_in("long_reach_in");
    Input = 8'h44;
    Enter = 1'b1;
    tick();
    check("long_a_after_in", Output, exp_q.pop_front());
    Input = 8'hAA;
    repeat (9) tick();
    check("long_inwait", state, ST_INWAIT);
    check("long_pc_hold", pc, 1);
    check("long_a_hold", Output, 8'h44);
    Enter = 1'b0;
    repeat (8) tick();
    check("long_second_in", state, ST_EXEC);
    check("long_second_ins", Ins, OP_IN);
    check("long_second_pc", pc, 3);
    check("long_a_kept", Output, 8'h44);
    feed(8'h11, 1, "long_op2");
    wait_halt("long_halt");
    check("long_sum", Output, exp_q.pop_front());

    // Reset while halted: state clears, RAM program survives, rerun works
    RESET = 1'b1;
    #1;
    check("rh_halt", Halt, 0);
    check("rh_out", Output, 0);
    check("rh_pc", pc, 0);
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("rh_ram%0d", i), dbg_rdata, boot_prog[i]);
    end
    run_add(8'h01, 8'h02, "rerun");

    // Branch program: A=0 takes JZ, A=80h does not take JPOS
    RESET = 1'b1;
    Init  = 1'b1;
    tick();
    Init   = 1'b0;
    dbg_wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      dbg_addr  = 5'(i);
      dbg_wdata = br_prog[i];
      tick();
    end
    dbg_addr = 5'd10; dbg_wdata = 8'h05; tick();
    dbg_addr = 5'd11; dbg_wdata = 8'h80; tick();
    dbg_wr = 1'b0;
    RESET  = 1'b0;
    wait_halt("br_halt");
    check("br_pc", pc, 9);
    check("br_a", Output, 8'h80);
    dbg_addr = 5'd12;
    #1;
    check("br_store", dbg_rdata, 8'h80);
    check("br_state", state, ST_HALT);
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
